// File: rtl/phase_clock_gen_if.sv
// Phase generator bus: run/step/mode controls toward the generator,
// phase strobes, system reset and cycle bookkeeping back to the CPU side.
interface phase_clock_gen_if #(
  parameter int unsigned NUM_PHASES = 4,
  parameter int unsigned CNT_W      = 16
);
  logic                  run;
  logic                  step;
  logic                  mode;
  logic [NUM_PHASES-1:0] phase;
  logic                  sys_reset;
  logic                  cycle_start;
  logic [CNT_W-1:0]      cycle_cnt;

  modport master (
    output run, step, mode,
    input  phase, sys_reset, cycle_start, cycle_cnt
  );

  modport slave (
    input  run, step, mode,
    output phase, sys_reset, cycle_start, cycle_cnt
  );
endinterface

// File: rtl/phase_clock_gen.sv
// Multiphase CPU timing generator: tick/slot counters, reset hold sequencing,
// run/stop/single-step control and registered phase decode.
module phase_clock_gen #(
  parameter int unsigned NUM_PHASES = 4,
  parameter int unsigned DIV        = 2,
  parameter int unsigned RST_HOLD   = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  phase_clock_gen_if.slave pcg
);

  localparam int unsigned TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SLOT_W = $clog2(NUM_PHASES);
  localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_PHASES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    IDLE    = 2'd1,
    RUNNING = 2'd2,
    LAST    = 2'd3
  } state_t;

  state_t                state,         state_nxt;
  logic [TICK_W-1:0]     tick,          tick_nxt;
  logic [SLOT_W-1:0]     slot,          slot_nxt;
  logic [HOLD_W-1:0]     hold_cnt,      hold_cnt_nxt;
  logic                  mode_q,        mode_nxt;
  logic                  wrap_q,        wrap_nxt;
  logic [NUM_PHASES-1:0] phase_q,       phase_nxt;
  logic                  sys_reset_q,   sys_reset_nxt;
  logic                  cycle_start_q, cycle_start_nxt;
  logic [CNT_W-1:0]      cycle_cnt_q,   cycle_cnt_nxt;

  logic active;
  logic first_tick;
  logic last_tick;
  logic slot_end;
  logic eff_mode;

  // Phase pattern for one slot: single strobe, or a half-cycle-wide window ending at slot.
  function automatic logic [NUM_PHASES-1:0] decode(input logic [SLOT_W-1:0] s, input logic m);
    logic [NUM_PHASES-1:0] p;
    p = '0;
    for (int unsigned k = 0; k < NUM_PHASES; k++) begin
      if (m) p[k] = (((32'(s) + NUM_PHASES - k) % NUM_PHASES) < (NUM_PHASES / 2));
      else   p[k] = (32'(s) == k);
    end
    return p;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HOLD;
      tick          <= '0;
      slot          <= '0;
      hold_cnt      <= '0;
      mode_q        <= 1'b0;
      wrap_q        <= 1'b0;
      phase_q       <= '0;
      sys_reset_q   <= 1'b0;
      cycle_start_q <= 1'b0;
      cycle_cnt_q   <= '0;
    end else begin
      state         <= state_nxt;
      tick          <= tick_nxt;
      slot          <= slot_nxt;
      hold_cnt      <= hold_cnt_nxt;
      mode_q        <= mode_nxt;
      wrap_q        <= wrap_nxt;
      phase_q       <= phase_nxt;
      sys_reset_q   <= sys_reset_nxt;
      cycle_start_q <= cycle_start_nxt;
      cycle_cnt_q   <= cycle_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    tick_nxt        = tick;
    slot_nxt        = slot;
    hold_cnt_nxt    = hold_cnt;
    mode_nxt        = mode_q;
    wrap_nxt        = 1'b0;
    phase_nxt       = '0;
    cycle_start_nxt = 1'b0;
    sys_reset_nxt   = (state != HOLD);
    cycle_cnt_nxt   = cycle_cnt_q + CNT_W'(wrap_q);

    first_tick = (tick == '0) && (slot == '0);
    slot_end   = (tick == TICK_LAST);
    last_tick  = slot_end && (slot == SLOT_LAST);
    // An idle generator starts a cycle on the same edge RUN or STEP is seen.
    active     = (state != IDLE) || pcg.run || pcg.step;
    eff_mode   = first_tick ? pcg.mode : mode_q;

    if (active) begin
      mode_nxt        = eff_mode;
      phase_nxt       = decode(slot, eff_mode);
      cycle_start_nxt = first_tick;
      wrap_nxt        = last_tick && (state != HOLD);

      if (slot_end) begin
        tick_nxt = '0;
        slot_nxt = last_tick ? '0 : slot + SLOT_W'(1);
      end else begin
        tick_nxt = tick + TICK_W'(1);
      end

      case (state)
        HOLD: begin
          if (last_tick) begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt_nxt = '0;
              state_nxt    = pcg.run ? RUNNING : IDLE;
            end else begin
              hold_cnt_nxt = hold_cnt + HOLD_W'(1);
            end
          end
        end
        IDLE: begin
          state_nxt = pcg.run ? RUNNING : LAST;
        end
        RUNNING, LAST: begin
          if (last_tick) state_nxt = pcg.run ? RUNNING : IDLE;
          else           state_nxt = pcg.run ? RUNNING : LAST;
        end
        default: state_nxt = HOLD;
      endcase
    end
  end

  assign pcg.phase       = phase_q;
  assign pcg.sys_reset   = sys_reset_q;
  assign pcg.cycle_start = cycle_start_q;
  assign pcg.cycle_cnt   = cycle_cnt_q;

endmodule
